// File: rtl/ifetch_pkg.sv
// Shared widths, FSM encodings and helpers for the Tiny86 instruction fetch buffer.
package ifetch_pkg;

  localparam int unsigned FETCH_WORDS = 5;
  localparam int unsigned FETCH_BYTES = 16;
  localparam int unsigned WORD_BITS   = 32;
  localparam int unsigned ADDR_BITS   = 32;
  localparam int unsigned CNT_BITS    = 3;
  localparam int unsigned WIN_BITS    = FETCH_WORDS * WORD_BITS;
  localparam int unsigned INSTR_BITS  = FETCH_BYTES * 8;

  typedef enum logic [1:0] {
    IF_IDLE  = 2'd0,
    IF_ISSUE = 2'd1,
    IF_WAIT  = 2'd2
  } if_state_e;

  function automatic logic [ADDR_BITS-1:0] word_align(input logic [ADDR_BITS-1:0] a);
    return {a[ADDR_BITS-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_window.sv
// Selects the 16 instruction bytes starting at byte offset off of the 20-byte window.
module ifetch_window
  import ifetch_pkg::*;
(
  input  logic [WIN_BITS-1:0]   window,
  input  logic [1:0]            off,
  output logic [INSTR_BITS-1:0] bytes
);

  always_comb begin
    bytes = window[INSTR_BITS-1:0];
    case (off)
      2'd1:    bytes = window[INSTR_BITS+7:8];
      2'd2:    bytes = window[INSTR_BITS+15:16];
      2'd3:    bytes = window[INSTR_BITS+23:24];
      default: bytes = window[INSTR_BITS-1:0];
    endcase
  end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch buffer: owns EIP, keeps a 5-word window of instruction memory
// and presents 16 bytes at EIP to decode; sequential targets reuse buffered words.
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [ADDR_BITS-1:0] RESET_EIP = 32'h0000_1000
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_BITS-1:0]  mem_req_addr,
  input  logic                  mem_rsp_valid,
  input  logic [WORD_BITS-1:0]  mem_rsp_data,
  output logic                  instr_valid,
  output logic [ADDR_BITS-1:0]  instr_eip,
  output logic [INSTR_BITS-1:0] instr_bytes,
  input  logic                  commit_valid,
  input  logic [ADDR_BITS-1:0]  next_eip
);

  if_state_e             state;
  logic [ADDR_BITS-1:0]  base;
  logic [ADDR_BITS-1:0]  eip;
  logic [CNT_BITS-1:0]   count;
  logic                  drop;
  logic [WORD_BITS-1:0]  wbuf [FETCH_WORDS];

  logic                  pend;
  logic [1:0]            off;
  logic                  rsp_take;
  logic                  rsp_write;
  logic                  commit;
  logic                  reuse;
  logic [ADDR_BITS-1:0]  delta;
  logic [CNT_BITS-1:0]   app_cnt;
  logic [CNT_BITS-1:0]   shift_k;
  logic [WORD_BITS-1:0]  app_buf [FETCH_WORDS];
  logic [WORD_BITS-1:0]  sh_buf  [FETCH_WORDS];
  logic [WIN_BITS-1:0]   window;
  logic [INSTR_BITS-1:0] sel_bytes;

  // Exactly one request is outstanding whenever the engine waits for data.
  assign pend      = (state == IF_WAIT);
  assign off       = eip[1:0];
  assign rsp_take  = pend & mem_rsp_valid;
  assign rsp_write = rsp_take & ~drop;

  assign instr_valid = (6'({count, 2'b00}) >= (6'(off) + 6'(FETCH_BYTES)));
  assign commit      = commit_valid & instr_valid;
  assign delta       = next_eip - base;

  assign mem_req_valid = (state == IF_ISSUE);
  assign mem_req_addr  = base + ADDR_BITS'({count, 2'b00});
  assign instr_eip     = eip;

  // Window after appending this cycle's response word.
  always_comb begin
    app_buf = wbuf;
    app_cnt = count;
    if (rsp_write) begin
      for (int i = 0; i < int'(FETCH_WORDS); i++) begin
        if (CNT_BITS'(i) == count) app_buf[i] = mem_rsp_data;
      end
      app_cnt = count + CNT_BITS'(1);
    end
  end

  assign reuse   = (delta < ADDR_BITS'({app_cnt, 2'b00}));
  assign shift_k = CNT_BITS'(delta[4:2]);

  // Shift the post-append window down by shift_k words on a reuse commit.
  always_comb begin
    sh_buf = app_buf;
    for (int i = 0; i < int'(FETCH_WORDS); i++) begin
      for (int j = 0; j < int'(FETCH_WORDS); j++) begin
        if (j == i + int'(shift_k)) sh_buf[i] = app_buf[j];
      end
    end
  end

  always_comb begin
    window = '0;
    for (int i = 0; i < int'(FETCH_WORDS); i++) begin
      window[i*WORD_BITS +: WORD_BITS] = wbuf[i];
    end
  end

  ifetch_window u_window (
    .window (window),
    .off    (off),
    .bytes  (sel_bytes)
  );

  assign instr_bytes = instr_valid ? sel_bytes : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IF_IDLE;
      base  <= word_align(RESET_EIP);
      eip   <= RESET_EIP;
      count <= '0;
      drop  <= 1'b0;
      for (int i = 0; i < int'(FETCH_WORDS); i++) wbuf[i] <= '0;
    end else begin
      unique case (state)
        IF_IDLE:  if (count < CNT_BITS'(FETCH_WORDS)) state <= IF_ISSUE;
        IF_ISSUE: if (mem_req_ready) state <= IF_WAIT;
        IF_WAIT:  if (mem_rsp_valid) state <= IF_IDLE;
        default:  state <= IF_IDLE;
      endcase

      if (commit && !reuse) begin
        // Flush: any response still to come for the old window must be discarded,
        // including a request that the memory accepts in this very cycle.
        base  <= word_align(next_eip);
        eip   <= next_eip;
        count <= '0;
        drop  <= (pend && !mem_rsp_valid) || ((state == IF_ISSUE) && mem_req_ready);
      end else if (commit) begin
        base  <= base + ADDR_BITS'({shift_k, 2'b00});
        eip   <= next_eip;
        count <= app_cnt - shift_k;
        wbuf  <= sh_buf;
        if (rsp_take) drop <= 1'b0;
      end else begin
        count <= app_cnt;
        wbuf  <= app_buf;
        if (rsp_take) drop <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: memory model with latency/hold knobs and an
// expected-request scoreboard, plus directed commit scenarios.
module tb_ifetch;

  logic         clk = 1'b0;
  logic         rst;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic [31:0]  mem_req_addr;
  logic         mem_rsp_valid;
  logic [31:0]  mem_rsp_data;
  logic         instr_valid;
  logic [31:0]  instr_eip;
  logic [127:0] instr_bytes;
  logic         commit_valid;
  logic [31:0]  next_eip;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_req[$];

  bit          ready_en  = 1'b1;
  bit          hold      = 1'b0;
  bit          stray     = 1'b0;
  int          lat       = 0;
  bit          slot_busy = 1'b0;
  logic [31:0] slot_addr = '0;
  int          slot_wait = 0;
  int          rsp_seen  = 0;
  logic [31:0] w0;

  always #5 clk = ~clk;

  ifetch #(.RESET_EIP(32'h0000_1002)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .instr_valid   (instr_valid),
    .instr_eip     (instr_eip),
    .instr_bytes   (instr_bytes),
    .commit_valid  (commit_valid),
    .next_eip      (next_eip)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mbyte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h3C;
  endfunction

  function automatic logic [31:0] mword(input logic [31:0] a);
    return {mbyte(a + 32'd3), mbyte(a + 32'd2), mbyte(a + 32'd1), mbyte(a)};
  endfunction

  function automatic logic [127:0] exp_bytes(input logic [31:0] e);
    logic [127:0] r = '0;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = mbyte(e + 32'(i));
    return r;
  endfunction

  task automatic push_run(input logic [31:0] a, input int n);
    for (int i = 0; i < n; i++) exp_req.push_back(a + 32'(4 * i));
  endtask

  task automatic commit(input logic [31:0] a);
    @(posedge clk); #1;
    commit_valid = 1'b1;
    next_eip     = a;
    @(posedge clk); #1;
    commit_valid = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_fill(input logic [31:0] e, input int words);
    bit ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      ok = instr_valid;
    end
    chk("fill_timeout", 128'(ok), 128'(1));
    if (words > 0) chk("fill_words", 128'(rsp_seen), 128'(words));
    chk("fill_eip", instr_eip, e);
    chk("fill_bytes", instr_bytes, exp_bytes(e));
  endtask

  task automatic wait_slot();
    bit ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(posedge clk); #2;
      ok = slot_busy;
    end
    chk("slot_timeout", 128'(ok), 128'(1));
  endtask

  // Memory: one outstanding word, response lat cycles after acceptance.
  initial begin
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        slot_busy = 1'b0;
      end else begin
        if (mem_rsp_valid) slot_busy = 1'b0;
        if (mem_req_valid && mem_req_ready) begin
          if (exp_req.size() > 0) chk("req_addr", mem_req_addr, exp_req.pop_front());
          slot_busy = 1'b1;
          slot_addr = mem_req_addr;
          slot_wait = lat;
        end
      end
      @(posedge clk); #1;
      mem_req_ready = ready_en;
      mem_rsp_valid = 1'b0;
      if (stray) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hDEAD_BEEF;
        stray         = 1'b0;
      end else if (slot_busy && !hold) begin
        if (slot_wait == 0) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = mword(slot_addr);
          rsp_seen++;
        end else begin
          slot_wait--;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    rst          = 1'b1;
    commit_valid = 1'b0;
    next_eip     = '0;
    push_run(32'h1000, 5);
    repeat (3) @(negedge clk);
    chk("rst_valid", 128'(instr_valid), 128'(0));
    chk("rst_req", 128'(mem_req_valid), 128'(0));
    chk("rst_eip", instr_eip, 32'h1002);
    chk("rst_bytes", instr_bytes, 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // Cold fill: valid only after the fifth word.
    wait_fill(32'h1002, 5);
    w0 = mword(32'h1000);
    chk("byte0", 128'(instr_bytes[7:0]), 128'(w0[23:16]));

    // Sequential commit: shift by one word, fetch continues at 0x1014.
    push_run(32'h1014, 1);
    commit(32'h1005);
    @(negedge clk);
    chk("seq_eip", instr_eip, 32'h1005);
    chk("seq_valid", 128'(instr_valid), 128'(0));
    wait_fill(32'h1005, 0);

    // Back-to-back reuse commits.
    push_run(32'h1018, 1);
    @(posedge clk); #1;
    commit_valid = 1'b1;
    next_eip     = 32'h1008;
    @(negedge clk);
    @(posedge clk); #1;
    next_eip = 32'h1009;
    @(negedge clk);
    chk("b2b_valid", 128'(instr_valid), 128'(1));
    chk("b2b_eip0", instr_eip, 32'h1008);
    @(posedge clk); #1;
    commit_valid = 1'b0;
    @(negedge clk);
    chk("b2b_eip1", instr_eip, 32'h1009);
    wait_fill(32'h1009, 0);

    // Jump while a request is pending: stale word dropped.
    settle(1);
    lat = 6;
    push_run(32'h101C, 1);
    commit(32'h100C);
    wait_slot();
    chk("jmp_pre_valid", 128'(instr_valid), 128'(1));
    push_run(32'h2000, 5);
    commit(32'h2003);
    lat = 0;
    @(negedge clk);
    chk("jmp_eip", instr_eip, 32'h2003);
    chk("jmp_valid", 128'(instr_valid), 128'(0));
    wait_fill(32'h2003, 0);

    // Far jump back to 0x1000, then a backward target that wraps delta.
    settle(2);
    push_run(32'h1000, 5);
    commit(32'h1000);
    wait_fill(32'h1000, 0);
    settle(6);
    push_run(32'h0FFC, 5);
    commit(32'h0FFC);
    @(negedge clk);
    chk("back_eip", instr_eip, 32'h0FFC);
    wait_fill(32'h0FFC, 0);
    settle(6);

    // Unaccepted request is retargeted by a flush.
    ready_en = 1'b0;
    commit(32'h1000);
    settle(3);
    chk("rt_req0", 128'(mem_req_valid), 128'(1));
    chk("rt_addr0", mem_req_addr, 32'h1010);
    push_run(32'h6000, 5);
    commit(32'h6002);
    @(negedge clk);
    chk("rt_req1", 128'(mem_req_valid), 128'(1));
    chk("rt_addr1", mem_req_addr, 32'h6000);
    #1;
    ready_en = 1'b1;
    wait_fill(32'h6002, 0);
    settle(6);

    // Fetch across the top of the address space.
    push_run(32'hFFFF_FFF8, 5);
    commit(32'hFFFF_FFFA);
    wait_fill(32'hFFFF_FFFA, 0);
    settle(6);

    // Response and flush commit in the same cycle, then an ignored commit.
    hold = 1'b1;
    push_run(32'h0000_000C, 1);
    commit(32'hFFFF_FFFC);
    wait_slot();
    push_run(32'h4000, 5);
    @(negedge clk);
    hold = 1'b0;
    @(posedge clk); #1;
    commit_valid = 1'b1;
    next_eip     = 32'h4001;
    @(posedge clk); #1;
    commit_valid = 1'b0;
    @(negedge clk);
    chk("same_eip", instr_eip, 32'h4001);
    chk("same_valid", 128'(instr_valid), 128'(0));
    @(posedge clk); #1;
    commit_valid = 1'b1;
    next_eip     = 32'h5000;
    @(posedge clk); #1;
    commit_valid = 1'b0;
    @(negedge clk);
    chk("ign_eip", instr_eip, 32'h4001);
    wait_fill(32'h4001, 0);
    settle(6);

    // Reset while waiting for a response, then a stray response.
    hold = 1'b1;
    push_run(32'h4014, 1);
    commit(32'h4004);
    wait_slot();
    push_run(32'h1000, 5);
    rsp_seen = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    hold  = 1'b0;
    stray = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst2_valid", 128'(instr_valid), 128'(0));
    chk("rst2_req", 128'(mem_req_valid), 128'(0));
    chk("rst2_eip", instr_eip, 32'h1002);
    chk("rst2_bytes", instr_bytes, 128'(0));
    wait_fill(32'h1002, 5);
    settle(4);

    chk("req_left", 128'(exp_req.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch buffer for Tiny86. It owns the architectural EIP register and fetches aligned 32-bit words from instruction memory into a 5-word window. It presents 16 instruction bytes starting at EIP to the decoder. It sits directly upstream of decode/execute and consumes the `next_eip` produced by the control flow unit. Sequential targets reuse already-buffered bytes; any other target flushes the window and refetches.

## Interface
- `RESET_EIP`, default 32'h0000_1000: EIP loaded on reset.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mem_req_valid`  out  1  word fetch request.
- `mem_req_ready`  in  1  memory accepts the request.
- `mem_req_addr`  out  32  word-aligned fetch address; `[1:0]` is always 0.
- `mem_rsp_valid`  in  1  response word present; one cycle wide; responses arrive in order.
- `mem_rsp_data`  in  32  response word, little-endian (byte 0 = lowest address).
- `instr_valid`  out  1  `instr_bytes` hold 16 valid bytes from `instr_eip`.
- `instr_eip`  out  32  current EIP.
- `instr_bytes`  out  128  byte i is located at `[8i+7:8i]` and is taken from address `instr_eip+i`.
- `commit_valid`  in  1  the current instruction has retired and `next_eip` is valid.
- `next_eip`  in  32  EIP of the next instruction, from the CFU.

## Operation
- State:
  - `base`: 32-bit, aligned, address of word 0.
  - `buf[0..4]`: 32-bit words.
  - `count`: 0..5, number of valid words.
  - `off`: 0..3, equal to `instr_eip - base`.
  - `pend`: 1 bit, one request outstanding.
  - `drop`: 1 bit, discard the next response.
- `instr_valid = (4*count >= off+16)`. `instr_bytes` = window bytes `off .. off+15`.
- Request engine FSM:
  - `IDLE`: if `count + pend < 5` and not `pend`, go to `ISSUE`.
  - `ISSUE`: `mem_req_valid=1`, `mem_req_addr = base + 4*count`. On `mem_req_ready`, set `pend` and go to `WAIT`.
  - `WAIT`: on `mem_rsp_valid`, clear `pend`. If `drop`, clear `drop` and discard the data. Otherwise write `buf[count]` and increment `count`. Then go to `IDLE`.
  - At most one outstanding request.
- `commit_valid` is honoured only while `instr_valid=1`; otherwise it is ignored.
- On commit, compute `delta = next_eip - base` (mod 2^32, unsigned):
  - **Reuse** (`delta < 4*count`): shift the window down by `k = delta[31:2]` words. `base += 4k`, `count -= k`, `off = delta[1:0]`.
  - **Flush** (otherwise): `base = {next_eip[31:2],2'b00}`, `count = 0`, `off = next_eip[1:0]`. If `pend` is set, or the response is arriving in the same cycle, set `drop`. A request in `ISSUE` not yet accepted is retargeted to the new `base`; `mem_req_addr` may change while `mem_req_valid` is high, only on a flush.
- Response and commit in the same cycle:
  - Reuse: the response word is appended first, then the shift is applied; `delta` is compared against the post-append `count`.
  - Flush: the response is discarded and `drop` is not set for it.
- Wrap-around: all address arithmetic is mod 2^32. Fetches past 32'hFFFF_FFFC continue at 0.

## Timing
- Reset values:
  - `instr_eip = RESET_EIP`, `base = {RESET_EIP[31:2],2'b00}`, `off = RESET_EIP[1:0]`.
  - `count = 0`, `pend = 0`, `drop = 0`.
  - `instr_valid = 0`, `mem_req_valid = 0`, FSM in `IDLE`, `instr_bytes = 0`.
- `rst` overrides everything in its cycle, including commit and response.
- Memory is reset by the same `rst`. A response seen with `pend=0` is ignored.
- `mem_req_valid` rises the cycle after `IDLE` sees room.
- With a zero-wait memory (ready=1, response the cycle after acceptance), each word takes 3 cycles.
- Commit takes effect on the next edge. `instr_valid` after a reuse commit is combinational from the new `count`/`off`, so back-to-back commits are possible with no bubble.

## Structure
- Shared package/defines: `FETCH_WORDS=5`, `FETCH_BYTES=16`, FSM state encodings `IF_IDLE`/`IF_ISSUE`/`IF_WAIT`.
- One sub-module, `ifetch_window`: a combinational 20-byte-to-16-byte byte selector indexed by `off`.

## Test plan
- Reset with `RESET_EIP`=32'h1002, zero-wait memory:
  - Requests go to 0x1000, 0x1004, 0x1008, 0x100C, 0x1010.
  - `instr_valid` rises only after the 5th word; `instr_bytes[7:0]` equals byte 2 of word 0x1000.
- Sequential commit, `next_eip`=32'h1005: no flush, `count` 5→4, `off`=1, next request to 0x1014; no refetch of 0x1004.
- Jump commit, `next_eip`=32'h2003 while a request is pending:
  - The pending response is discarded (`drop`).
  - Next request is to 0x2000; `instr_eip`=0x2003.
- Backward target, `next_eip`=32'h0FFC with `base`=0x1000: `delta` wraps large, flush occurs, fetch restarts at 0x0FFC.
- Response and flush commit in the same cycle: `count`=0 afterwards and `buf` is not written from the stale data.
- `commit_valid` asserted with `instr_valid=0`: ignored, EIP unchanged.
- `rst` asserted mid-`WAIT`: all outputs take reset values; a stray `mem_rsp_valid` the next cycle does not increment `count`.
